regbank_multi: RTL and testbench
================================

Name: regbank_multi

Overview:
- Parametrised successor of the single-mode 32-bit register file.
- Configurable data width and register count.
- Per-register access modes: read/write (RW), read-only with a hardware load path (RO), and write-1-to-clear with a hardware set path (W1C).
- Registered read port with valid/error flags, write error reporting, and an aggregated interrupt from W1C registers.
- Sits behind the AXI4-Lite slave as its register backing store; exposes all register contents to the design.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- NREG, 16: number of registers; 2..256, not necessarily a power of two.
- RO_MASK, '0 (NREG bits): bit i=1 makes register i read-only to software.
- W1C_MASK, '0 (NREG bits): bit i=1 makes register i W1C; RO_MASK takes priority where both are set.
- RESET_VAL, '0 (DATA_W bits): reset value of every register.
- Derived localparams: IDX_W = max(1, $clog2(NREG)); STRB_W = DATA_W/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  software write request, single-cycle.
- wr_idx  in  IDX_W  write register index.
- wr_data  in  DATA_W  write data.
- wr_strb  in  STRB_W  byte strobes.
- wr_err  out  1  registered pulse: write was to an out-of-range index or an RO register.
- rd_en  in  1  software read request.
- rd_idx  in  IDX_W  read register index.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  pulse, one cycle after rd_en.
- rd_err  out  1  pulse with rd_valid when the read index is out of range.
- hw_load_en  in  NREG  per-register hardware load strobe; honoured for RO registers only.
- hw_load_data  in  NREG*DATA_W  load data; register i occupies slice [i*DATA_W +: DATA_W].
- hw_set  in  NREG*DATA_W  per-bit set pulses; honoured for W1C registers only.
- regs_q  out  NREG*DATA_W  flattened current register contents.
- irq  out  1  registered OR of all bits of all W1C registers.

Behaviour:
- Reset (async, rst_n=0): all registers = RESET_VAL; rd_data=0, rd_valid=0, rd_err=0, wr_err=0, irq=0.
- Out-of-range index means idx >= NREG. Possible only when NREG is not a power of two.
- RW write (wr_en=1, valid idx, RW register): each byte b with wr_strb[b]=1 is replaced by the matching wr_data byte; other bytes are held. Update visible on regs_q the next cycle.
- RO write: register unchanged; wr_err=1 the next cycle.
- RO hardware load: hw_load_en[i]=1 loads the full hw_load_data slice into register i.
- W1C software write: in each strobed byte, every wr_data bit equal to 1 clears that register bit. Unstrobed bytes and 0 bits are unaffected.
- W1C hardware set: hw_set bits set register bits every cycle.
- W1C collision: if a hardware set and a software clear hit the same bit in the same cycle, the set wins and the bit ends at 1.
- Ignored hardware inputs: hw_load_en on non-RO registers and hw_set on non-W1C registers have no effect.
- Out-of-range write: no register changes; wr_err=1 the next cycle.
- Strobes: wr_strb=0 on a valid write leaves the register unchanged, and wr_err=0.
- Read latency is 1 cycle: rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1.
  - rd_data is the register value before the clock edge ending cycle N (read-before-write).
  - A same-cycle write to the same index is not forwarded.
- Out-of-range read: rd_data=0 and rd_err=1.
- When rd_valid=0, rd_data holds its last value.
- Concurrent traffic: reads and writes are independent and can occur in the same cycle.
- Back-to-back rd_en gives back-to-back rd_valid.
- irq is registered, lagging the W1C state by one cycle: it asserts the cycle after any W1C bit becomes 1 and deasserts the cycle after all W1C bits are 0.
- Reset mid-operation: a pending rd_valid or wr_err is dropped; all outputs return to their reset values immediately.

Test Plan:
- RW strobes: DATA_W=32, NREG=16, RESET_VAL=0. Write idx 3 with 0xAABBCCDD, strb=0b0101, then read idx 3 → one cycle after rd_en: rd_valid=1, rd_data=0x00BB00DD, rd_err=0.
- Read-before-write: in the same cycle, write 0x12345678 (strb=0xF) to idx 5 and read idx 5 (prior value 0) → rd_data=0. A read on the next cycle → 0x12345678.
- RO register (RO_MASK bit 2 set):
  - Software write 0xFFFFFFFF to idx 2 → wr_err pulse; register stays 0.
  - hw_load_en[2] with data 0xCAFE0001 → regs_q slice 2 = 0xCAFE0001.
- W1C register 7 (W1C_MASK bit 7 set):
  - hw_set slice 7 = 0x0000_0081 → register = 0x81; irq=1 one cycle later.
  - Software write 0x01 (strb=0x1) → register = 0x80.
  - Software write 0x80 in the same cycle as hw_set bit 7 → register stays 0x80.
  - Software write 0x80 alone → register = 0, irq=0 one cycle later.
- Out of range, NREG=12: write idx 13 → wr_err=1, no regs_q change. Read idx 15 → rd_valid=1, rd_err=1, rd_data=0.
- Reset mid-read: assert rst_n=0 in the cycle after rd_en → rd_valid drops to 0 asynchronously; all registers = RESET_VAL; irq=0.

Source files
------------

// File: rtl/regbank_multi.sv
// Parametrised register bank with per-register access modes (RW, RO with a
// hardware load path, W1C with a hardware set path), a registered read port,
// write error reporting and an aggregated interrupt from the W1C registers.
module regbank_multi #(
  parameter int                DATA_W    = 32,
  parameter int                NREG      = 16,
  parameter logic [NREG-1:0]   RO_MASK   = '0,
  parameter logic [NREG-1:0]   W1C_MASK  = '0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               IDX_W     = (NREG > 2) ? $clog2(NREG) : 1,
  localparam int               STRB_W    = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [STRB_W-1:0]      wr_strb,
  output logic                   wr_err,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   rd_err,
  input  logic [NREG-1:0]        hw_load_en,
  input  logic [NREG*DATA_W-1:0] hw_load_data,
  input  logic [NREG*DATA_W-1:0] hw_set,
  output logic [NREG*DATA_W-1:0] regs_q,
  output logic                   irq
);

  logic [DATA_W-1:0] regs   [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] byte_mask;
  logic              wr_hit_any;
  logic              wr_hit_ro;
  logic              wr_err_d;
  logic              rd_hit_any;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] w1c_or;

  // Expand byte strobes into a bit mask
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  // Next-state per register; an index matching no register is out of range.
  // RO takes priority over W1C, and a hardware set beats a software clear.
  always_comb begin
    wr_hit_any = 1'b0;
    wr_hit_ro  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        wr_hit_any = 1'b1;
        if (RO_MASK[i]) begin
          wr_hit_ro = 1'b1;
        end
      end
      if (RO_MASK[i]) begin
        if (hw_load_en[i]) begin
          regs_d[i] = hw_load_data[i*DATA_W +: DATA_W];
        end
      end else if (W1C_MASK[i]) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          regs_d[i] = regs[i] & ~(wr_data & byte_mask);
        end
        regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        regs_d[i] = (regs[i] & ~byte_mask) | (wr_data & byte_mask);
      end
    end
    wr_err_d = wr_en && (!wr_hit_any || wr_hit_ro);
  end

  // Read mux and W1C interrupt aggregation from the current register values
  always_comb begin
    rd_hit_any = 1'b0;
    rd_sel     = '0;
    w1c_or     = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_hit_any = 1'b1;
        rd_sel     = regs[i];
      end
      if (W1C_MASK[i] && !RO_MASK[i]) begin
        w1c_or = w1c_or | regs[i];
      end
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= regs_d[i];
      end
    end
  end

  // Read port, write error pulse and interrupt; rd_data holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_hit_any;
      if (rd_en) begin
        rd_data <= rd_hit_any ? rd_sel : '0;
      end
      wr_err <= wr_err_d;
      irq    <= |w1c_or;
    end
  end

  // Flattened register contents for the design
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_q[i*DATA_W +: DATA_W] = regs[i];
    end
  end

endmodule

// File: tb/tb_regbank_multi.sv
// Self-checking bench for regbank_multi: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regbank_multi;

  localparam int DW = 32;
  localparam int NR = 12;
  localparam int IW = 4;
  localparam int SW = 4;
  // Register 2 is both RO and W1C so that RO priority gets exercised.
  localparam logic [NR-1:0] RO  = 12'b0010_0000_0100;
  localparam logic [NR-1:0] W1C = 12'b0100_1000_0100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic             wr_err;
  logic             rd_en;
  logic [IW-1:0]    rd_idx;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             rd_err;
  logic [NR-1:0]    hw_load_en;
  logic [NR*DW-1:0] hw_load_data;
  logic [NR*DW-1:0] hw_set;
  logic [NR*DW-1:0] regs_q;
  logic             irq;

  regbank_multi #(
    .DATA_W(DW), .NREG(NR), .RO_MASK(RO), .W1C_MASK(W1C), .RESET_VAL('0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_err(wr_err),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err),
    .hw_load_en(hw_load_en), .hw_load_data(hw_load_data), .hw_set(hw_set),
    .regs_q(regs_q), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid, exp_rd_err, exp_wr_err, exp_irq;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs,
                     input logic [NR*DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic idle();
    wr_en = 0; wr_idx = '0; wr_data = '0; wr_strb = '0;
    rd_en = 0; rd_idx = '0;
    hw_load_en = '0; hw_load_data = '0; hw_set = '0;
  endtask

  // One clock: predict from the current inputs, clock, then compare everything.
  task automatic step(input string tag);
    logic [DW-1:0] nm [NR];
    logic [DW-1:0] mask;
    logic          any_w1c;
    int            wi, ri;
    wi = int'(wr_idx);
    ri = int'(rd_idx);
    mask = '0;
    for (int b = 0; b < SW; b++) if (wr_strb[b]) mask[b*8 +: 8] = 8'hFF;
    any_w1c = 0;
    for (int i = 0; i < NR; i++) begin
      nm[i] = model[i];
      if (W1C[i] && !RO[i] && model[i] != 0) any_w1c = 1;
      if (RO[i]) begin
        if (hw_load_en[i]) nm[i] = hw_load_data[i*DW +: DW];
      end else if (W1C[i]) begin
        if (wr_en && wi == i) nm[i] = nm[i] & ~(wr_data & mask);
        nm[i] = nm[i] | hw_set[i*DW +: DW];
      end else if (wr_en && wi == i) begin
        nm[i] = (model[i] & ~mask) | (wr_data & mask);
      end
    end
    exp_wr_err   = wr_en && (wi >= NR || RO[wi % NR] && wi < NR);
    exp_rd_valid = rd_en;
    exp_rd_err   = rd_en && ri >= NR;
    if (rd_en) exp_rd_data = (ri >= NR) ? '0 : model[ri];
    exp_irq = any_w1c;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) model[i] = nm[i];
    chk({tag, ".rd_valid"}, rd_valid, exp_rd_valid);
    chk({tag, ".rd_err"},   rd_err,   exp_rd_err);
    chk({tag, ".rd_data"},  rd_data,  exp_rd_data);
    chk({tag, ".wr_err"},   wr_err,   exp_wr_err);
    chk({tag, ".irq"},      irq,      exp_irq);
    chk({tag, ".regs_q"},   regs_q,   model_flat());
  endtask

  task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr_en = 1; wr_idx = IW'(idx); wr_data = d; wr_strb = s;
  endtask

  task automatic do_read(input int idx);
    rd_en = 1; rd_idx = IW'(idx);
  endtask

  initial begin
    idle();
    rst_n = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.regs_q",   regs_q,   '0);
    chk("reset.rd_valid", rd_valid, 1'b0);
    chk("reset.rd_data",  rd_data,  '0);
    chk("reset.wr_err",   wr_err,   1'b0);
    chk("reset.irq",      irq,      1'b0);
    rst_n = 1;

    // RW strobes
    do_write(3, 32'hAABBCCDD, 4'b0101); step("rw_wr"); idle();
    do_read(3); step("rw_rd"); idle();
    chk("rw_strb.data", rd_data, 32'h00BB00DD);
    chk("rw_strb.valid", rd_valid, 1'b1);

    // Read-before-write on the same index
    do_write(5, 32'h12345678, 4'hF); do_read(5); step("rbw"); idle();
    chk("rbw.old", rd_data, 32'h0);
    do_read(5); step("rbw2"); idle();
    chk("rbw.new", rd_data, 32'h12345678);

    // Zero strobes: no change, no error
    do_write(5, 32'hFFFFFFFF, 4'h0); step("strb0"); idle();
    chk("strb0.reg", regs_q[5*DW +: DW], 32'h12345678);

    // RO register 2
    do_write(2, 32'hFFFFFFFF, 4'hF); step("ro_wr"); idle();
    chk("ro_wr.err", wr_err, 1'b1);
    chk("ro_wr.reg", regs_q[2*DW +: DW], 32'h0);
    hw_load_en[2] = 1; hw_load_data[2*DW +: DW] = 32'hCAFE0001; step("ro_ld"); idle();
    chk("ro_ld.reg", regs_q[2*DW +: DW], 32'hCAFE0001);
    hw_set[2*DW +: DW] = 32'h0000FF00; hw_load_en[3] = 1; hw_load_data[3*DW +: DW] = 32'h5;
    step("ignored_hw"); idle();
    chk("ro_noset.reg", regs_q[2*DW +: DW], 32'hCAFE0001);

    // W1C register 7
    hw_set[7*DW +: DW] = 32'h81; step("w1c_set"); idle();
    chk("w1c_set.reg", regs_q[7*DW +: DW], 32'h81);
    step("w1c_irq");
    chk("w1c_irq.on", irq, 1'b1);
    do_write(7, 32'h01, 4'h1); step("w1c_clr1"); idle();
    chk("w1c_clr1.reg", regs_q[7*DW +: DW], 32'h80);
    do_write(7, 32'h80, 4'hF); hw_set[7*DW + 7] = 1'b1; step("w1c_coll"); idle();
    chk("w1c_coll.reg", regs_q[7*DW +: DW], 32'h80);
    do_write(7, 32'h80, 4'hF); step("w1c_clr2"); idle();
    chk("w1c_clr2.reg", regs_q[7*DW +: DW], 32'h0);
    step("w1c_irqoff");
    chk("w1c_irq.off", irq, 1'b0);

    // Out of range
    do_write(13, 32'hDEADBEEF, 4'hF); step("oor_wr"); idle();
    chk("oor_wr.err", wr_err, 1'b1);
    do_read(15); step("oor_rd"); idle();
    chk("oor_rd.err", rd_err, 1'b1);
    chk("oor_rd.data", rd_data, 32'h0);

    // Randomized concurrent traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, 15), $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1)
        do_read($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        hw_load_en = NR'($urandom);
        for (int i = 0; i < NR; i++) hw_load_data[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NR; i++) hw_set[i*DW +: DW] = $urandom & $urandom & $urandom;
      step("rand");
    end

    // Reset in the cycle after a read request
    idle();
    hw_set[10*DW +: DW] = 32'h4; step("pre_rst"); idle();
    do_read(7); step("rst_rd"); idle();
    chk("rst_rd.valid_before", rd_valid, 1'b1);
    #1 rst_n = 0;
    #1;
    chk("rst.rd_valid", rd_valid, 1'b0);
    chk("rst.regs_q",   regs_q,   '0);
    chk("rst.irq",      irq,      1'b0);
    chk("rst.wr_err",   wr_err,   1'b0);
    chk("rst.rd_data",  rd_data,  '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
